uart_mmio_fifo: RTL

Memory-mapped UART peripheral that replaces the discrete tx/tx_data/rx_ready/rx_data/clean_rx register set on the multicycle core's data bus. It adds real serial TX/RX engines, parametrised TX and RX FIFOs, and a programmable baud divisor. It also provides a status register with sticky error flags and an interrupt line. It sits beside Instruction_Data_Memory behind MemControl and decodes a small word-offset register window.

---
 rtl/uart_mmio_pkg.sv | 39 +++
 rtl/sync_fifo.sv | 66 ++++++
 rtl/uart_mmio_fifo.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_mmio_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_mmio_pkg
// Purpose  : Shared constants and types for the memory-mapped UART. Holds the
//            register word offsets, the STATUS bit positions, the state
//            encoding shared by the TX and RX engines, and the divisor floor.
// Revision : 1.0  initial release
// ============================================================================
package uart_mmio_pkg;

    // Register window, word offsets (byte address bits [4:2])
    localparam logic [2:0] TXDATA  = 3'd0;
    localparam logic [2:0] RXDATA  = 3'd1;
    localparam logic [2:0] RXPOP   = 3'd2;
    localparam logic [2:0] STATUS  = 3'd3;
    localparam logic [2:0] BAUDDIV = 3'd4;

    // STATUS bit positions
    localparam int STAT_TX_FULL    = 0;
    localparam int STAT_TX_EMPTY   = 1;
    localparam int STAT_RX_FULL    = 2;
    localparam int STAT_RX_EMPTY   = 3;
    localparam int STAT_RX_OVERRUN = 4;
    localparam int STAT_FRAME_ERR  = 5;
    localparam int STAT_TX_DROP    = 6;
    localparam int STAT_TX_BUSY    = 7;

    // Smallest clocks-per-bit the engines will run at
    localparam int MIN_DIV = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock FIFO with separate occupancy counter. A push while
//            full is accepted only when a pop happens in the same cycle; a pop
//            while empty is ignored.
// Ports    : clk, reset (async, active low)
//            push/wdata  - write side
//            pop/rdata   - read side, rdata shows the head (show-ahead)
//            full/empty  - occupancy flags
// Revision : 1.0  initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign empty     = (r_count == '0);
    assign full      = (r_count == (PTR_W+1)'(DEPTH));
    assign w_do_pop  = pop && !empty;
    // A full FIFO still takes a push when the head leaves in the same cycle
    assign w_do_push = push && (!full || w_do_pop);
    assign rdata     = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_mmio_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_mmio_fifo
// Purpose  : Memory-mapped UART with TX/RX FIFOs, programmable baud divisor,
//            sticky error flags (write-1-to-clear) and a level interrupt.
//            Frame format: start, DATA_BITS data LSB first, one stop bit.
// Ports    : clk, reset (async, active low)
//            sel_i/addr_i/wdata_i/we_i - bus access, addr_i is a word offset
//            rdata_o                   - combinational read data, 0 if !sel_i
//            rx_i  - asynchronous serial input
//            tx_o  - serial output, idles high
//            irq_o - RX data pending or RX error flag set (registered)
// Revision : 1.0  initial release
// ============================================================================
module uart_mmio_fifo
    import uart_mmio_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int DATA_BITS   = 8,
    parameter int FIFO_DEPTH  = 8,
    parameter int DIV_WIDTH   = 16,
    parameter int DEFAULT_DIV = 434
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sel_i,
    input  logic [2:0]            addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  we_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    input  logic                  rx_i,
    output logic                  tx_o,
    output logic                  irq_o
);
    // ---------------- bus decode ----------------
    logic w_wr, w_tx_push_req, w_rx_pop_req, w_stat_wr, w_baud_wr;
    assign w_wr          = sel_i && we_i;
    assign w_tx_push_req = w_wr && (addr_i == TXDATA);
    assign w_rx_pop_req  = w_wr && (addr_i == RXPOP);
    assign w_stat_wr     = w_wr && (addr_i == STATUS);
    assign w_baud_wr     = w_wr && (addr_i == BAUDDIV);

    logic [DIV_WIDTH-1:0] r_baud;
    logic [DIV_WIDTH-1:0] w_div_eff;
    assign w_div_eff = (r_baud < DIV_WIDTH'(MIN_DIV)) ? DIV_WIDTH'(MIN_DIV) : r_baud;

    // ---------------- FIFOs ----------------
    logic                 w_tx_pop, w_tx_full, w_tx_empty;
    logic [DATA_BITS-1:0] w_tx_head;
    logic                 w_rx_push, w_rx_full, w_rx_empty;
    logic [DATA_BITS-1:0] w_rx_head;
    logic [DATA_BITS-1:0] r_rx_shift;

    sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .reset(reset),
        .push(w_tx_push_req), .pop(w_tx_pop), .wdata(wdata_i[DATA_BITS-1:0]),
        .rdata(w_tx_head), .full(w_tx_full), .empty(w_tx_empty)
    );

    sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .reset(reset),
        .push(w_rx_push), .pop(w_rx_pop_req), .wdata(r_rx_shift),
        .rdata(w_rx_head), .full(w_rx_full), .empty(w_rx_empty)
    );

    // ---------------- TX engine ----------------
    uart_state_t          r_tx_state;
    logic [DIV_WIDTH-1:0] r_tx_cnt, r_tx_div;
    logic [DATA_BITS-1:0] r_tx_shift;
    logic [3:0]           r_tx_bit;
    logic                 r_tx_line;
    logic                 w_tx_stop_end;

    assign w_tx_stop_end = (r_tx_state == STOP) && (r_tx_cnt == r_tx_div - 1'b1);
    // Reload straight from the end of STOP so queued frames run back to back
    assign w_tx_pop = !w_tx_empty && ((r_tx_state == IDLE) || w_tx_stop_end);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx_state <= IDLE;
            r_tx_cnt   <= '0;
            r_tx_div   <= DIV_WIDTH'(DEFAULT_DIV);
            r_tx_shift <= '0;
            r_tx_bit   <= '0;
            r_tx_line  <= 1'b1;
        end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
            case (r_tx_state)
                IDLE: begin
                    r_tx_cnt <= '0;
                end
                START: begin
                    if (r_tx_cnt == r_tx_div - 1'b1) begin
                        r_tx_cnt   <= '0;
                        r_tx_line  <= r_tx_shift[0];
                        r_tx_shift <= r_tx_shift >> 1;
                        r_tx_bit   <= '0;
                        r_tx_state <= DATA;
                    end
                end
                DATA: begin
                    if (r_tx_cnt == r_tx_div - 1'b1) begin
                        r_tx_cnt <= '0;
                        if (r_tx_bit == 4'(DATA_BITS - 1)) begin
                            r_tx_line  <= 1'b1;
                            r_tx_state <= STOP;
                        end else begin
                            r_tx_bit   <= r_tx_bit + 4'd1;
                            r_tx_line  <= r_tx_shift[0];
                            r_tx_shift <= r_tx_shift >> 1;
                        end
                    end
                end
                STOP: begin
                    if (w_tx_stop_end) begin
                        r_tx_cnt   <= '0;
                        r_tx_state <= IDLE;
                    end
                end
                default: r_tx_state <= IDLE;
            endcase
            // Frame start overrides the per-state update above
            if (w_tx_pop) begin
                r_tx_shift <= w_tx_head;
                r_tx_div   <= w_div_eff;
                r_tx_cnt   <= '0;
                r_tx_line  <= 1'b0;
                r_tx_state <= START;
            end
        end
    end

    // ---------------- RX engine ----------------
    logic                 r_rx_s1, r_rx_s2, r_rx_prev;
    uart_state_t          r_rx_state;
    logic [DIV_WIDTH-1:0] r_rx_cnt, r_rx_div;
    logic [3:0]           r_rx_bit;
    logic                 r_rx_fe_wait;
    logic                 w_rx_stop_smp, w_frame_set, w_ovr_set;

    assign w_rx_stop_smp = (r_rx_state == STOP) && !r_rx_fe_wait &&
                           (r_rx_cnt == r_rx_div - 1'b1);
    assign w_rx_push     = w_rx_stop_smp && r_rx_s2;
    assign w_frame_set   = w_rx_stop_smp && !r_rx_s2;
    assign w_ovr_set     = w_rx_push && w_rx_full && !w_rx_pop_req;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_s1      <= 1'b1;
            r_rx_s2      <= 1'b1;
            r_rx_prev    <= 1'b1;
            r_rx_state   <= IDLE;
            r_rx_cnt     <= '0;
            r_rx_div     <= DIV_WIDTH'(DEFAULT_DIV);
            r_rx_bit     <= '0;
            r_rx_shift   <= '0;
            r_rx_fe_wait <= 1'b0;
        end else begin
            r_rx_s1   <= rx_i;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= r_rx_s2;
            r_rx_cnt  <= r_rx_cnt + 1'b1;
            case (r_rx_state)
                IDLE: begin
                    r_rx_cnt <= '0;
                    if (r_rx_prev && !r_rx_s2) begin
                        r_rx_div   <= w_div_eff;
                        r_rx_state <= START;
                    end
                end
                START: begin
                    // Mid start bit: a high line here means it was a glitch
                    if (r_rx_cnt == (r_rx_div >> 1) - 1'b1) begin
                        r_rx_cnt   <= '0;
                        r_rx_bit   <= '0;
                        r_rx_state <= r_rx_s2 ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (r_rx_cnt == r_rx_div - 1'b1) begin
                        r_rx_cnt   <= '0;
                        r_rx_shift <= {r_rx_s2, r_rx_shift[DATA_BITS-1:1]};
                        if (r_rx_bit == 4'(DATA_BITS - 1)) r_rx_state <= STOP;
                        else                               r_rx_bit   <= r_rx_bit + 4'd1;
                    end
                end
                STOP: begin
                    if (r_rx_fe_wait) begin
                        // Hold off until the line is released after a bad stop bit
                        if (r_rx_s2) begin
                            r_rx_fe_wait <= 1'b0;
                            r_rx_state   <= IDLE;
                        end
                    end else if (w_rx_stop_smp) begin
                        r_rx_cnt <= '0;
                        if (r_rx_s2) r_rx_state   <= IDLE;
                        else         r_rx_fe_wait <= 1'b1;
                    end
                end
                default: r_rx_state <= IDLE;
            endcase
        end
    end

    // ---------------- registers, flags, irq ----------------
    logic r_rx_overrun, r_frame_err, r_tx_drop, r_irq;
    logic w_tx_drop_set;
    assign w_tx_drop_set = w_tx_push_req && w_tx_full && !w_tx_pop;

    // Set events win over a simultaneous write-1-to-clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_baud       <= DIV_WIDTH'(DEFAULT_DIV);
            r_rx_overrun <= 1'b0;
            r_frame_err  <= 1'b0;
            r_tx_drop    <= 1'b0;
            r_irq        <= 1'b0;
        end else begin
            if (w_baud_wr) r_baud <= wdata_i[DIV_WIDTH-1:0];
            r_rx_overrun <= w_ovr_set ||
                            (r_rx_overrun && !(w_stat_wr && wdata_i[STAT_RX_OVERRUN]));
            r_frame_err  <= w_frame_set ||
                            (r_frame_err && !(w_stat_wr && wdata_i[STAT_FRAME_ERR]));
            r_tx_drop    <= w_tx_drop_set ||
                            (r_tx_drop && !(w_stat_wr && wdata_i[STAT_TX_DROP]));
            r_irq        <= !w_rx_empty || r_rx_overrun || r_frame_err;
        end
    end

    logic [7:0] w_status;
    assign w_status = {(r_tx_state != IDLE), r_tx_drop, r_frame_err, r_rx_overrun,
                       w_rx_empty, w_rx_full, w_tx_empty, w_tx_full};

    always_comb begin
        rdata_o = '0;
        if (sel_i) begin
            case (addr_i)
                RXDATA:  rdata_o[DATA_BITS-1:0] = w_rx_head;
                STATUS:  rdata_o[7:0]           = w_status;
                BAUDDIV: rdata_o[DIV_WIDTH-1:0] = r_baud;
                default: rdata_o                = '0;
            endcase
        end
    end

    // Only a subset of the write-data bits is meaningful
    logic w_unused;
    assign w_unused = ^wdata_i;

    assign tx_o  = r_tx_line;
    assign irq_o = r_irq;

endmodule
`default_nettype wire
